vgg_result_packer: RTL and testbench
====================================

Name: vgg_result_packer

Overview:
- Downstream neighbour of the VGG inference core in the SDE stream-reflection path.
- Takes the core's narrow 16-bit result stream (valid/ready) and packs 32 results into each full 512-bit AXI-stream beat, lowest word in the lowest bits. Output drives the 512-bit AXIS output FIFO.
- Marks frame boundaries with last and keep so the host receives dense results, not one 16-bit word per 64-byte beat.

Parameters:
- IN_W, 16, result word width in bits.
- OUT_W, 512, output beat width in bits; WORDS = OUT_W/IN_W = 32.
- LEN_W, 24, width of the frame-length configuration input.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- frame_len  in  LEN_W  result words per frame; 0 = unframed.
- flush  in  1  single-cycle pulse; forces out the partial beat with last=1.
- in_valid  in  1  result word valid.
- in_ready  out  1  result word accepted when in_valid && in_ready.
- in_data  in  IN_W  result word.
- out_valid  out  1  AXIS tvalid.
- out_ready  in  1  AXIS tready.
- out_data  out  OUT_W  packed beat; word k at [16k+15:16k]; unused words are 0.
- out_keep  out  OUT_W/8  byte enables: 2 bits per valid word, contiguous from bit 0.
- out_user  out  64  [15:0] frame sequence number (wraps); [21:16] valid word count 1..32; rest 0.
- out_last  out  1  final beat of a frame or flush.
- frames_done  out  32  frames emitted with last; wraps.
- idle  out  1  assembly empty and out_valid low.

Behaviour:
- Two stages:
  - Assembly register asm_buf, with slot count asm_cnt (0..32), frame word counter fcnt (LEN_W bits) and flag asm_done.
  - Output register holding out_*.
- in_ready = !asm_done || !out_valid || out_ready. This gives full throughput: the move and the next accept happen in the same cycle.
- Accept: in_data is written to slot asm_cnt, then asm_cnt++ and fcnt++.
- asm_done sets on any of:
  - the accepted word fills slot 31;
  - frame_len != 0 and the accepted word is word frame_len-1 of the frame (last=1, fcnt returns to 0);
  - flush is high while asm_cnt+accept > 0 (last=1, fcnt returns to 0).
- Move: when asm_done && (!out_valid || out_ready), asm_buf/keep/user/last load into the output register, out_valid=1, and the assembly clears. If an accept happens in the same cycle, that word lands in slot 0 of the new assembly.
- Output stability: the output holds stable while out_valid && !out_ready (AXIS rule). out_valid drops the cycle after a handshake unless a move occurs.
- frame_len sampling: sampled when the first word of a frame is accepted (fcnt==0). Changes mid-frame are ignored until the next frame.
- Unframed mode (frame_len==0): beats emit only when full, out_last=0; flush still emits a partial beat with last=1.
- Flush with empty assembly and no accept: no beat emitted; fcnt cleared.
- Flush coincident with the 32nd word or the frame-end word: one beat, last=1; no empty extra beat.
- frames_done and the frame sequence number increment at the move of a beat with last=1.
- Reset values: out_valid=0, out_data=0, out_keep=0, out_user=0, out_last=0, asm_cnt=0, fcnt=0, asm_done=0, frames_done=0, sequence=0, idle=1. in_ready is 1 once reset deasserts.
- Reset mid-frame: the partial assembly and a pending output beat are discarded with no output.
- in_valid with in_ready low: the word is not taken; the source must hold it.

Decomposition:
- Shared package sde_pkg holds:
  - localparams RES_W=16, AXIS_W=512, WORDS_PER_BEAT=32;
  - a packed struct for the AXIS beat {data, keep, user, last};
  - a function keep_from_count(n) returning 2n low-order ones.
- No sub-module: assembly and output register are one file, ~200 lines.

Test Plan:
- frame_len=64, 64 words 0x0000..0x003F with out_ready=1 -> two beats, keep=all-ones both. Beat 0 word0=0x0000, last=0; beat 1 word31=0x003F, last=1, user[21:16]=32, frames_done=1.
- frame_len=40, words 1..40 -> beat 0 full (last=0); beat 1 words 33..40 in [127:0], keep=0x...FFFF (16 bits), data[511:128]=0, last=1, user[21:16]=8.
- out_ready=0 for 100 cycles while streaming 96 words -> at most 64 words accepted, then in_ready=0. out_data is held stable. On release, all beats arrive in order with no loss or duplication.
- frame_len=0, 5 words then flush pulse -> one beat, keep=0x3FF, last=1. A second flush with empty assembly produces no beat.
- Flush on the same cycle as the 32nd accepted word -> exactly one beat, keep all-ones, last=1, fcnt=0.
- Reset asserted with 10 words assembled and one beat pending -> out_valid=0 next cycle, frames_done=0. The next frame starts at slot 0 with sequence 0.

Source files
------------

// File: rtl/sde_pkg.sv
// sde_pkg: shared widths, AXIS beat layout and keep helper for the SDE result path
package sde_pkg;
    localparam int RES_W = 16;
    localparam int AXIS_W = 512;
    localparam int WORDS_PER_BEAT = AXIS_W / RES_W;
    localparam int KEEP_W = AXIS_W / 8;
    localparam int USER_W = 64;

    typedef struct packed {
        logic [AXIS_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [USER_W-1:0] user;
        logic              last;
    } beat_t;

    function automatic logic [KEEP_W-1:0] keep_from_count(input int n);
        logic [KEEP_W-1:0] k;
        for (int i = 0; i < KEEP_W; i++) k[i] = (i < 2 * n) && (n <= WORDS_PER_BEAT);
        return k;
    endfunction
endpackage

// File: rtl/vgg_result_packer_if.sv
// vgg_result_packer_if: narrow result stream in, packed AXIS beat out
interface vgg_result_packer_if #(
    parameter int IN_W = sde_pkg::RES_W,
    parameter int OUT_W = sde_pkg::AXIS_W
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [OUT_W/8-1:0] out_keep;
    logic [63:0]      out_user;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_user, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_user, out_last
    );
endinterface

// File: rtl/vgg_result_packer.sv
// vgg_result_packer: packs 16-bit results into 512-bit AXIS beats with frame last/keep
module vgg_result_packer
    import sde_pkg::*;
#(
    parameter int IN_W = RES_W,
    parameter int OUT_W = AXIS_W,
    parameter int LEN_W = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             flush,
    vgg_result_packer_if.slave bus,
    output logic [31:0]      frames_done,
    output logic             idle
);
    localparam int WORDS = OUT_W / IN_W;
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int IDX_W = $clog2(WORDS);

    logic [WORDS-1:0][IN_W-1:0] asm_buf, buf_n;
    logic [CNT_W-1:0] asm_cnt, cnt_n;
    logic [LEN_W-1:0] fcnt, fcnt_n, flen, flen_eff;
    logic             asm_done, done_n, asm_last, last_n;
    logic             accept, move, out_valid_q;
    logic [15:0]      seq;
    beat_t            out_q;

    // A finished assembly can only leave when the output register is free or draining,
    // and a new word is only refused when a finished assembly is stuck behind it.
    assign move = asm_done && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = !asm_done || !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready;
    assign flen_eff = (fcnt == '0) ? frame_len : flen;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data = out_q.data;
    assign bus.out_keep = out_q.keep;
    assign bus.out_user = out_q.user;
    assign bus.out_last = out_q.last;
    assign idle = (asm_cnt == '0) && !out_valid_q;

    // Next assembly: clear on move, place the accepted word, then decide whether it closes
    always_comb begin
        buf_n = move ? '0 : asm_buf;
        cnt_n = move ? '0 : asm_cnt;
        done_n = move ? 1'b0 : asm_done;
        last_n = move ? 1'b0 : asm_last;
        fcnt_n = fcnt;
        if (accept) begin
            buf_n[cnt_n[IDX_W-1:0]] = bus.in_data;
            cnt_n = cnt_n + 1'b1;
            fcnt_n = fcnt + 1'b1;
            done_n = done_n || (cnt_n == CNT_W'(WORDS));
            if (flen_eff != '0 && fcnt_n == flen_eff) begin
                done_n = 1'b1;
                last_n = 1'b1;
                fcnt_n = '0;
            end
        end
        if (flush) begin
            done_n = done_n || (cnt_n != '0);
            last_n = last_n || (cnt_n != '0);
            fcnt_n = '0;
        end
    end

    // Assembly state, output register and frame counters
    always_ff @(posedge clock) begin
        if (reset) begin
            asm_buf <= '0;
            asm_cnt <= '0;
            asm_done <= 1'b0;
            asm_last <= 1'b0;
            fcnt <= '0;
            flen <= '0;
            out_valid_q <= 1'b0;
            out_q <= '0;
            seq <= '0;
            frames_done <= '0;
        end else begin
            asm_buf <= buf_n;
            asm_cnt <= cnt_n;
            asm_done <= done_n;
            asm_last <= last_n;
            fcnt <= fcnt_n;
            if (accept && fcnt == '0) flen <= frame_len;
            if (move) begin
                out_valid_q <= 1'b1;
                out_q <= '{data: asm_buf, keep: keep_from_count(int'(asm_cnt)),
                           user: USER_W'({asm_cnt, seq}), last: asm_last};
                if (asm_last) begin
                    seq <= seq + 1'b1;
                    frames_done <= frames_done + 1'b1;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vgg_result_packer.sv
// tb_vgg_result_packer: directed vectors with a scoreboard queue and a decoupled beat monitor
module tb_vgg_result_packer;
    import sde_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [23:0] frame_len = '0;
    logic [31:0] frames_done;
    logic        idle;

    vgg_result_packer_if bus ();

    vgg_result_packer dut (
        .clock(clock),
        .reset(reset),
        .frame_len(frame_len),
        .flush(flush),
        .bus(bus),
        .frames_done(frames_done),
        .idle(idle)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    beat_t       exp_q[$];
    beat_t       e;
    logic [15:0] exp_seq = '0;
    logic        hold = 1'b0;
    logic [511:0] held = '0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beat: n valid words, keep built arithmetically, user = {count, sequence}
    task automatic expect_beat(input logic [511:0] d, input int n, input logic last);
        beat_t b;
        b.data = d;
        b.keep = (n >= 32) ? {64{1'b1}} : ((64'd1 << (2 * n)) - 64'd1);
        b.user = {42'd0, 6'(n), exp_seq};
        b.last = last;
        exp_q.push_back(b);
        if (last) exp_seq++;
    endtask

    task automatic push(input logic [15:0] d, input logic fl);
        int  t = 0;
        bit  took = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        while (!took && t < 300) begin
            flush = fl;
            #1;
            took = bus.in_ready;
            @(negedge clock);
            t++;
        end
        bus.in_valid = 1'b0;
        flush = 1'b0;
        if (took) acc_cnt++;
        else begin
            checks++;
            errors++;
            $display("FAIL push_timeout: word %0h not accepted after %0d cycles", d, t);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clock);
            t++;
        end
        repeat (2) @(negedge clock);
        chk("drain_left", 512'(exp_q.size()), 512'(0));
    endtask

    // Monitor: pops the scoreboard on each handshake and checks a stalled beat stays put
    always begin
        @(negedge clock);
        #2;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got user %0h last %0b, expected no beat", bus.out_user, bus.out_last);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", bus.out_data, e.data);
                chk("beat_keep", 512'(bus.out_keep), 512'(e.keep));
                chk("beat_user", 512'(bus.out_user), 512'(e.user));
                chk("beat_last", 512'(bus.out_last), 512'(e.last));
            end
        end
        if (hold && bus.out_valid) chk("hold_stable", bus.out_data, held);
        hold = bus.out_valid && !bus.out_ready;
        held = bus.out_data;
    end

    initial begin
        logic [511:0] d0, d1, d2;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 512'(bus.out_valid), 512'(0));
        chk("rst_out_data", bus.out_data, 512'(0));
        chk("rst_out_keep", 512'(bus.out_keep), 512'(0));
        chk("rst_out_user", 512'(bus.out_user), 512'(0));
        chk("rst_out_last", 512'(bus.out_last), 512'(0));
        chk("rst_frames_done", 512'(frames_done), 512'(0));
        chk("rst_idle", 512'(idle), 512'(1));
        chk("rst_in_ready", 512'(bus.in_ready), 512'(1));
        @(negedge clock);

        // Framed 64 words: two full beats, second carries last
        frame_len = 24'd64;
        for (int k = 0; k < 32; k++) begin
            d0[16*k +: 16] = 16'(k);
            d1[16*k +: 16] = 16'(32 + k);
        end
        expect_beat(d0, 32, 1'b0);
        expect_beat(d1, 32, 1'b1);
        for (int i = 0; i < 64; i++) push(16'(i), 1'b0);
        drain();
        chk("f64_frames_done", 512'(frames_done), 512'(1));

        // Framed 40 words: full beat then an 8-word tail with zeroed upper words
        frame_len = 24'd40;
        d1 = '0;
        for (int k = 0; k < 32; k++) d0[16*k +: 16] = 16'(k + 1);
        for (int k = 0; k < 8; k++) d1[16*k +: 16] = 16'(33 + k);
        expect_beat(d0, 32, 1'b0);
        expect_beat(d1, 8, 1'b1);
        for (int i = 1; i <= 40; i++) push(16'(i), 1'b0);
        drain();
        chk("f40_frames_done", 512'(frames_done), 512'(2));

        // Backpressure: 96 unframed words while the sink stalls for 100 cycles
        frame_len = 24'd0;
        bus.out_ready = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            d0[16*k +: 16] = 16'h1000 + 16'(k);
            d1[16*k +: 16] = 16'h1020 + 16'(k);
            d2[16*k +: 16] = 16'h1040 + 16'(k);
        end
        expect_beat(d0, 32, 1'b0);
        expect_beat(d1, 32, 1'b0);
        expect_beat(d2, 32, 1'b0);
        fork
            for (int i = 0; i < 96; i++) push(16'h1000 + 16'(i), 1'b0);
            begin
                repeat (100) @(negedge clock);
                #3;
                chk("stall_accepted", 512'(acc_cnt), 512'(64));
                chk("stall_in_ready", 512'(bus.in_ready), 512'(0));
                @(negedge clock);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_total", 512'(acc_cnt), 512'(96));

        // Unframed partial flushed out, then an empty flush that must emit nothing
        d0 = '0;
        for (int k = 0; k < 5; k++) d0[16*k +: 16] = 16'hA0 + 16'(k);
        expect_beat(d0, 5, 1'b1);
        for (int i = 0; i < 5; i++) push(16'hA0 + 16'(i), 1'b0);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        drain();
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        repeat (10) @(negedge clock);
        chk("flush_idle", 512'(idle), 512'(1));
        chk("flush_frames_done", 512'(frames_done), 512'(3));

        // Flush coincident with the 32nd word: exactly one full beat with last
        for (int k = 0; k < 32; k++) d0[16*k +: 16] = 16'h2000 + 16'(k);
        expect_beat(d0, 32, 1'b1);
        for (int i = 0; i < 32; i++) push(16'h2000 + 16'(i), i == 31);
        drain();
        chk("flush32_frames_done", 512'(frames_done), 512'(4));

        // Frame counter restarted, so a new 2-word frame length is picked up
        frame_len = 24'd2;
        d0 = '0;
        d0[31:0] = {16'h3001, 16'h3000};
        expect_beat(d0, 2, 1'b1);
        push(16'h3000, 1'b0);
        push(16'h3001, 1'b0);
        drain();
        chk("f2_frames_done", 512'(frames_done), 512'(5));

        // Reset with a pending beat and 10 words assembled: everything discarded
        frame_len = 24'd0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 42; i++) push(16'h4000 + 16'(i), 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 512'(bus.out_valid), 512'(0));
        chk("mid_rst_frames_done", 512'(frames_done), 512'(0));
        chk("mid_rst_idle", 512'(idle), 512'(1));
        exp_seq = '0;
        bus.out_ready = 1'b1;
        frame_len = 24'd3;
        @(negedge clock);
        d0 = '0;
        d0[47:0] = {16'hBEE2, 16'hBEE1, 16'hBEE0};
        expect_beat(d0, 3, 1'b1);
        for (int i = 0; i < 3; i++) push(16'hBEE0 + 16'(i), 1'b0);
        drain();
        chk("post_rst_frames_done", 512'(frames_done), 512'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
